// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared encodings and the register-match helper for the hazard/stall sequencer.
package pipeline_stall_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_HAZ = 2'd1,
    ST_FRZ = 2'd2
  } state_t;

  // Register 0 is hardwired, so a write to it can never create a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] r,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             uses_rt);
    return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction
endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at MAX instead of wrapping.
module sat_counter #(
  parameter int           W   = 16,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (clear)               cnt <= '0;
    else if (inc && (cnt != MAX)) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall sequencer: combinational pipeline-register enables, flush and bubble,
// plus a registered status FSM, freeze watchdog and saturating stall statistics.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_br_use,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             redirect,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic [1:0]       state,
  output logic             timeout_err,
  output logic [CNT_W-1:0] haz_cnt,
  output logic [CNT_W-1:0] frz_cnt
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic ld_use, br_ex, br_mem, haz, frz;
  logic [WD_W-1:0] wd_cnt;
  state_t cur_state, nxt_state;

  assign ld_use = ex_memread && reg_match(ex_rd, id_rs, id_rt, id_uses_rt);
  assign br_ex  = id_br_use && ex_regwrite && reg_match(ex_rd, id_rs, id_rt, id_uses_rt);
  assign br_mem = id_br_use && mem_memread && reg_match(mem_rd, id_rs, id_rt, id_uses_rt);
  assign haz    = ld_use | br_ex | br_mem;
  assign frz    = icache_stall | dcache_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= ST_RUN;
    else     cur_state <= nxt_state;
  end

  // The FSM is status only; the enables below never look at it.
  always_comb begin
    nxt_state = ST_RUN;
    if (frz)      nxt_state = ST_FRZ;
    else if (haz) nxt_state = ST_HAZ;
  end

  assign state = cur_state;

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_we     = 1'b1;
    idex_bubble = 1'b0;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    if (rst) begin
      ifid_flush = 1'b0;
    end else if (frz) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (haz) begin
      // Operands are stale, so the redirect cannot be trusted yet: no flush.
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      ifid_flush = redirect;
    end
  end

  sat_counter #(.W(CNT_W)) u_haz_cnt (
    .clk(clk), .rst(rst), .inc(haz && !frz), .clear(1'b0), .cnt(haz_cnt)
  );

  sat_counter #(.W(CNT_W)) u_frz_cnt (
    .clk(clk), .rst(rst), .inc(frz), .clear(1'b0), .cnt(frz_cnt)
  );

  sat_counter #(.W(WD_W), .MAX(WD_W'(TIMEOUT))) u_watchdog (
    .clk(clk), .rst(rst), .inc(frz), .clear(!frz), .cnt(wd_cnt)
  );

  // Set on the same edge that brings the watchdog up to TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        timeout_err <= 1'b0;
    else if (frz && (wd_cnt >= WD_W'(TIMEOUT - 1))) timeout_err <= 1'b1;
  end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed plus randomized stimulus against a behavioural model of the stall sequencer.
module tb_pipeline_stall_ctrl;
  localparam int TO    = 4;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic id_uses_rt, id_br_use, ex_memread, ex_regwrite, mem_memread;
  logic redirect, icache_stall, dcache_stall;
  logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we;
  logic [1:0] state;
  logic timeout_err;
  logic [CNT_W-1:0] haz_cnt, frz_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  int m_state, m_haz, m_frz, m_wd;
  bit m_err;

  pipeline_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_br_use(id_br_use),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .mem_memread(mem_memread), .mem_rd(mem_rd), .redirect(redirect),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
    .idex_bubble(idex_bubble), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .state(state), .timeout_err(timeout_err), .haz_cnt(haz_cnt), .frz_cnt(frz_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit depends(input logic [4:0] r);
    if (r == 0) return 0;
    return (r == id_rs) || (id_uses_rt && r == id_rt);
  endfunction

  function automatic bit m_hazard();
    bit lu, be, bm;
    lu = ex_memread && depends(ex_rd);
    be = id_br_use && ex_regwrite && depends(ex_rd);
    bm = id_br_use && mem_memread && depends(mem_rd);
    return lu || be || bm;
  endfunction

  // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we}
  function automatic logic [6:0] m_ctl();
    if (rst) return 7'b1101011;
    if (icache_stall || dcache_stall) return 7'b0000000;
    if (m_hazard()) return 7'b0001111;
    return {2'b11, redirect, 4'b1011};
  endfunction

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
    id_uses_rt = 0; id_br_use = 0; ex_memread = 0; ex_regwrite = 0; mem_memread = 0;
    redirect = 0; icache_stall = 0; dcache_stall = 0;
  endtask

  task automatic check_all();
    check("ctl", {25'd0, pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we},
          {25'd0, m_ctl()});
    check("state", {30'd0, state}, m_state);
    check("haz_cnt", {28'd0, haz_cnt}, m_haz);
    check("frz_cnt", {28'd0, frz_cnt}, m_frz);
    check("timeout_err", {31'd0, timeout_err}, {31'd0, m_err});
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle();
    bit f, h;
    #4;
    check_all();
    f = icache_stall || dcache_stall;
    h = m_hazard();
    @(posedge clk);
    m_state = f ? 2 : (h ? 1 : 0);
    if (h && !f && m_haz < MAXC) m_haz++;
    if (f && m_frz < MAXC) m_frz++;
    if (f) begin
      if (m_wd < TO) m_wd++;
      if (m_wd == TO) m_err = 1;
    end else begin
      m_wd = 0;
    end
    #1;
  endtask

  // Asynchronous reset pulse inside a cycle, checked before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_state = 0; m_haz = 0; m_frz = 0; m_wd = 0; m_err = 0;
    check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    m_state = 0; m_haz = 0; m_frz = 0; m_wd = 0; m_err = 0;
    @(posedge clk); #1;
    do_reset();
    cycle();

    // Load-use on rs
    ex_memread = 1; ex_rd = 8; id_rs = 8;
    cycle();
    clear_inputs();
    cycle();

    // lw then dependent beq on rt: two bubbles, then the flush
    ex_memread = 1; ex_regwrite = 1; ex_rd = 9; id_rt = 9; id_uses_rt = 1; id_br_use = 1;
    cycle();
    ex_memread = 0; ex_regwrite = 0; ex_rd = 0; mem_memread = 1; mem_rd = 9;
    cycle();
    clear_inputs(); redirect = 1;
    cycle();
    clear_inputs();

    // Register zero never matches
    ex_memread = 1; ex_rd = 0; id_rs = 0; ex_regwrite = 1; id_br_use = 1;
    cycle();
    clear_inputs();

    // dcache freeze while a hazard and redirect are pending
    for (int i = 0; i < 5; i++) begin
      dcache_stall = 1; ex_memread = 1; ex_rd = 3; id_rs = 3; redirect = 1;
      cycle();
    end
    dcache_stall = 0;
    cycle();
    clear_inputs(); redirect = 1;
    cycle();
    clear_inputs();
    cycle();

    // Watchdog: six icache freeze cycles with TIMEOUT=4
    icache_stall = 1;
    for (int i = 0; i < 6; i++) cycle();
    icache_stall = 0;
    cycle();
    cycle();
    // Reset in the middle of a new freeze
    icache_stall = 1;
    cycle();
    do_reset();
    clear_inputs();
    cycle();

    // Short freeze bursts must not trip the watchdog once cleared
    for (int k = 0; k < 3; k++) begin
      icache_stall = 1; cycle(); cycle(); cycle();
      icache_stall = 0; cycle();
    end

    // Randomized traffic with a small register range to provoke matches
    for (int i = 0; i < 400; i++) begin
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      mem_rd       = 5'($urandom_range(0, 3));
      id_uses_rt   = 1'($urandom_range(0, 1));
      id_br_use    = 1'($urandom_range(0, 1));
      ex_memread   = 1'($urandom_range(0, 2) == 0);
      ex_regwrite  = 1'($urandom_range(0, 1));
      mem_memread  = 1'($urandom_range(0, 2) == 0);
      redirect     = 1'($urandom_range(0, 2) == 0);
      icache_stall = 1'($urandom_range(0, 5) == 0);
      dcache_stall = 1'($urandom_range(0, 5) == 0);
      if (i % 97 == 50) begin
        icache_stall = 1;
        repeat (5) cycle();
      end
      cycle();
      if (i == 200) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
